// File: rtl/banco_registradores_8_if.sv
// Request/response bundle between the register file and its user (decode stage / operand mux).
// The master issues writes and read requests; the slave (register file) returns registered read data.
interface banco_registradores_8_if #(
  parameter int LARGURA  = 8,
  parameter int BITS_END = 2
);
  logic                EscritaHabilitada;
  logic [BITS_END-1:0] EnderecoEscrita;
  logic [LARGURA-1:0]  DadoEscrita;
  logic                LeituraValida;
  logic [BITS_END-1:0] EnderecoLeitura0;
  logic [BITS_END-1:0] EnderecoLeitura1;
  logic [LARGURA-1:0]  Dado0;
  logic [LARGURA-1:0]  Dado1;
  logic                SaidaValida;

  modport master (
    output EscritaHabilitada, EnderecoEscrita, DadoEscrita,
    output LeituraValida, EnderecoLeitura0, EnderecoLeitura1,
    input  Dado0, Dado1, SaidaValida
  );

  modport slave (
    input  EscritaHabilitada, EnderecoEscrita, DadoEscrita,
    input  LeituraValida, EnderecoLeitura0, EnderecoLeitura1,
    output Dado0, Dado1, SaidaValida
  );
endinterface

// File: rtl/banco_registradores_8.sv
// 2**BITS_END x LARGURA register file: one synchronous write port, two registered read ports
// with one-cycle latency, a response-valid flag and write-first bypass on each read port.
module banco_registradores_8 #(
  parameter int LARGURA  = 8,
  parameter int BITS_END = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  banco_registradores_8_if.slave bus
);

  localparam int NUM_REGS = 2 ** BITS_END;

  typedef logic [LARGURA-1:0] palavra_t;

  palavra_t regs_q [NUM_REGS];
  palavra_t regs_d [NUM_REGS];
  palavra_t dado0_q, dado0_d;
  palavra_t dado1_q, dado1_d;
  logic     valida_q, valida_d;

  logic bypass0, bypass1;

  // Write-first: a same-cycle write to the addressed register wins over the stored value.
  assign bypass0 = bus.EscritaHabilitada && (bus.EnderecoLeitura0 == bus.EnderecoEscrita);
  assign bypass1 = bus.EscritaHabilitada && (bus.EnderecoLeitura1 == bus.EnderecoEscrita);

  always_comb begin
    // NOTE: every signal gets a default before any condition, so no path leaves it unassigned (no latch).
    regs_d   = regs_q;
    dado0_d  = dado0_q;
    dado1_d  = dado1_q;
    valida_d = 1'b0;

    if (bus.EscritaHabilitada) begin
      regs_d[bus.EnderecoEscrita] = bus.DadoEscrita;
    end

    // Without a request the outputs hold, so the downstream mux sees stable data.
    if (bus.LeituraValida) begin
      dado0_d  = bypass0 ? bus.DadoEscrita : regs_q[bus.EnderecoLeitura0];
      dado1_d  = bypass1 ? bus.DadoEscrita : regs_q[bus.EnderecoLeitura1];
      valida_d = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      // NOTE: the storage array is reset on purpose; register contents must read as zero after reset.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      dado0_q  <= '0;
      dado1_q  <= '0;
      valida_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      dado0_q  <= dado0_d;
      dado1_q  <= dado1_d;
      valida_q <= valida_d;
    end
  end

  assign bus.Dado0       = dado0_q;
  assign bus.Dado1       = dado1_q;
  assign bus.SaidaValida = valida_q;

endmodule

// File: tb/tb_banco_registradores_8.sv
// Directed bench for banco_registradores_8: stimulus pushes expected read responses into a
// queue, a monitor pops and compares them whenever SaidaValida is seen.
module tb_banco_registradores_8;

  localparam int LARGURA  = 8;
  localparam int BITS_END = 2;

  logic Clock = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  typedef struct packed {
    logic [LARGURA-1:0] d0;
    logic [LARGURA-1:0] d1;
  } resp_t;

  resp_t esperado_q[$];

  banco_registradores_8_if #(.LARGURA(LARGURA), .BITS_END(BITS_END)) bus ();

  banco_registradores_8 #(.LARGURA(LARGURA), .BITS_END(BITS_END)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Downstream 2:1 operand mux: Controle=1 selects Entrada1 (tied to zero here).
  logic               controle;
  logic [LARGURA-1:0] resultado;
  assign resultado = controle ? 8'h00 : bus.Dado0;

  always #5 Clock = ~Clock;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  // One cycle of stimulus, driven on the falling edge; a read pushes its expected response.
  task automatic ciclo(input logic rst, input logic we, input logic [1:0] wa, input logic [7:0] wd,
                       input logic re, input logic [1:0] ra0, input logic [1:0] ra1,
                       input logic [7:0] e0, input logic [7:0] e1);
    @(negedge Clock);
    Reset                 = rst;
    bus.EscritaHabilitada = we;
    bus.EnderecoEscrita   = wa;
    bus.DadoEscrita       = wd;
    bus.LeituraValida     = re;
    bus.EnderecoLeitura0  = ra0;
    bus.EnderecoLeitura1  = ra1;
    if (re && !rst) esperado_q.push_back('{d0: e0, d1: e1});
  endtask

  task automatic ocioso();
    ciclo(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    resp_t r;
    forever begin
      @(posedge Clock);
      #1;
      if (bus.SaidaValida === 1'b1) begin
        if (esperado_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got SaidaValida=1 expected 0 (no pending read)");
        end else begin
          r = esperado_q.pop_front();
          check("Dado0", {24'h0, bus.Dado0}, {24'h0, r.d0});
          check("Dado1", {24'h0, bus.Dado1}, {24'h0, r.d1});
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    controle = 1'b0;
    Reset = 1'b1;
    bus.EscritaHabilitada = 1'b0;
    bus.EnderecoEscrita   = '0;
    bus.DadoEscrita       = '0;
    bus.LeituraValida     = 1'b0;
    bus.EnderecoLeitura0  = '0;
    bus.EnderecoLeitura1  = '0;

    // Reset for two cycles.
    ciclo(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00);
    ciclo(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00);
    ocioso();
    @(posedge Clock); #1;
    check("reset_Dado0", {24'h0, bus.Dado0}, 32'h0);
    check("reset_Dado1", {24'h0, bus.Dado1}, 32'h0);
    check("reset_valida", {31'h0, bus.SaidaValida}, 32'h0);

    // All four registers read zero, back-to-back.
    ciclo(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd1, 8'h00, 8'h00);
    ciclo(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd3, 8'h00, 8'h00);

    // Plain writes, then read.
    ciclo(1'b0, 1'b1, 2'd1, 8'hA5, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00);
    ciclo(1'b0, 1'b1, 2'd2, 8'h3C, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00);
    ciclo(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd2, 8'hA5, 8'h3C);

    // Hold: outputs stable and valid low while no read is requested.
    for (int i = 0; i < 3; i++) begin
      ocioso();
      @(posedge Clock); #1;
      check("hold_Dado0", {24'h0, bus.Dado0}, 32'hA5);
      check("hold_Dado1", {24'h0, bus.Dado1}, 32'h3C);
      check("hold_valida", {31'h0, bus.SaidaValida}, 32'h0);
    end

    // Bypass on both ports to the same register.
    ciclo(1'b0, 1'b1, 2'd3, 8'hFF, 1'b1, 2'd3, 2'd3, 8'hFF, 8'hFF);
    // Bypass on port 0 only (index 0 writable), then on port 1 only.
    ciclo(1'b0, 1'b1, 2'd0, 8'h11, 1'b1, 2'd0, 2'd1, 8'h11, 8'hA5);
    ciclo(1'b0, 1'b1, 2'd1, 8'h22, 1'b1, 2'd2, 2'd1, 8'h3C, 8'h22);
    // Write without read, then read it back along with r0 and r3.
    ciclo(1'b0, 1'b1, 2'd2, 8'h44, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00);
    ciclo(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd0, 8'h44, 8'h11);
    ciclo(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd1, 8'hFF, 8'h22);

    // Reset beats a same-cycle write and read.
    ciclo(1'b1, 1'b1, 2'd0, 8'h77, 1'b1, 2'd0, 2'd0, 8'h00, 8'h00);
    @(posedge Clock); #1;
    check("rst_mid_valida", {31'h0, bus.SaidaValida}, 32'h0);
    check("rst_mid_Dado0", {24'h0, bus.Dado0}, 32'h0);
    check("rst_mid_Dado1", {24'h0, bus.Dado1}, 32'h0);
    ciclo(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd3, 8'h00, 8'h00);
    ciclo(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd2, 8'h00, 8'h00);

    // Operand mux driven by Dado0 with Controle toggling each cycle.
    ciclo(1'b0, 1'b1, 2'd1, 8'h5A, 1'b0, 2'd0, 2'd0, 8'h00, 8'h00);
    ciclo(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd1, 8'h5A, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      ocioso();
      controle = i[0];
      @(posedge Clock); #1;
      check("mux_Resultado", {24'h0, resultado}, (i % 2 == 1) ? 32'h00 : 32'h5A);
    end

    ocioso();
    ocioso();
    @(posedge Clock); #1;
    check("pending_responses", esperado_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
